// File: rtl/ctrl_decoder_if.sv
// Instruction word in, one-hot decode strobes out.
// The decoder drives the strobes; the pipeline drives I.
interface ctrl_decoder_if;
  logic [31:0] I;
  logic lb, lbu, lh, lhu, lw;
  logic sb, sh, sw;
  logic R;
  logic add, addu, sub, subu, slt, sltu;
  logic and_, or_, xor_, nor_;
  logic sll, srl, sra, sllv, srlv, srav;
  logic mult, multu, div, divu;
  logic mfhi, mflo, mthi, mtlo;
  logic addi, addiu, andi, ori;
  logic xori, lui, slti, sltiu;
  logic beq, bne, blez, bgtz, bltz, bgez;
  logic j, jal, jalr, jr;
  logic eret, mfc0, mtc0;

  modport master (
    output I,
    input  lb, lbu, lh, lhu, lw, sb, sh, sw, R,
    input  add, addu, sub, subu, slt, sltu,
    input  and_, or_, xor_, nor_,
    input  sll, srl, sra, sllv, srlv, srav,
    input  mult, multu, div, divu,
    input  mfhi, mflo, mthi, mtlo,
    input  addi, addiu, andi, ori,
    input  xori, lui, slti, sltiu,
    input  beq, bne, blez, bgtz, bltz, bgez,
    input  j, jal, jalr, jr,
    input  eret, mfc0, mtc0
  );

  modport slave (
    input  I,
    output lb, lbu, lh, lhu, lw, sb, sh, sw, R,
    output add, addu, sub, subu, slt, sltu,
    output and_, or_, xor_, nor_,
    output sll, srl, sra, sllv, srlv, srav,
    output mult, multu, div, divu,
    output mfhi, mflo, mthi, mtlo,
    output addi, addiu, andi, ori,
    output xori, lui, slti, sltiu,
    output beq, bne, blez, bgtz, bltz, bgez,
    output j, jal, jalr, jr,
    output eret, mfc0, mtc0
  );
endinterface

// File: rtl/ctrl_decoder.sv
// Purely combinational MIPS instruction decoder.
// Equality-based decode keeps X on I visible at the strobes.
module ctrl_decoder (
  input logic         clk,
  input logic         reset,
  ctrl_decoder_if.slave bus
);
  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       sp;
  logic       rim;
  logic       cp0;
  logic       unused_clk_rst;

  assign op  = bus.I[31:26];
  assign rs  = bus.I[25:21];
  assign rt  = bus.I[20:16];
  assign fn  = bus.I[5:0];
  assign sp  = (op == 6'b000000);
  assign rim = (op == 6'b000001);
  assign cp0 = (op == 6'b010000);

  // No state here; clock and reset are present only for uniformity.
  assign unused_clk_rst = clk ^ reset;

  assign bus.lb  = (op == 6'b100000);
  assign bus.lh  = (op == 6'b100001);
  assign bus.lw  = (op == 6'b100011);
  assign bus.lbu = (op == 6'b100100);
  assign bus.lhu = (op == 6'b100101);
  assign bus.sb  = (op == 6'b101000);
  assign bus.sh  = (op == 6'b101001);
  assign bus.sw  = (op == 6'b101011);

  assign bus.R = sp;

  assign bus.sll   = sp & (fn == 6'b000000);
  assign bus.srl   = sp & (fn == 6'b000010);
  assign bus.sra   = sp & (fn == 6'b000011);
  assign bus.sllv  = sp & (fn == 6'b000100);
  assign bus.srlv  = sp & (fn == 6'b000110);
  assign bus.srav  = sp & (fn == 6'b000111);
  assign bus.jr    = sp & (fn == 6'b001000);
  assign bus.jalr  = sp & (fn == 6'b001001);
  assign bus.mfhi  = sp & (fn == 6'b010000);
  assign bus.mthi  = sp & (fn == 6'b010001);
  assign bus.mflo  = sp & (fn == 6'b010010);
  assign bus.mtlo  = sp & (fn == 6'b010011);
  assign bus.mult  = sp & (fn == 6'b011000);
  assign bus.multu = sp & (fn == 6'b011001);
  assign bus.div   = sp & (fn == 6'b011010);
  assign bus.divu  = sp & (fn == 6'b011011);
  assign bus.add   = sp & (fn == 6'b100000);
  assign bus.addu  = sp & (fn == 6'b100001);
  assign bus.sub   = sp & (fn == 6'b100010);
  assign bus.subu  = sp & (fn == 6'b100011);
  assign bus.and_  = sp & (fn == 6'b100100);
  assign bus.or_   = sp & (fn == 6'b100101);
  assign bus.xor_  = sp & (fn == 6'b100110);
  assign bus.nor_  = sp & (fn == 6'b100111);
  assign bus.slt   = sp & (fn == 6'b101010);
  assign bus.sltu  = sp & (fn == 6'b101011);

  assign bus.j     = (op == 6'b000010);
  assign bus.jal   = (op == 6'b000011);
  assign bus.beq   = (op == 6'b000100);
  assign bus.bne   = (op == 6'b000101);
  assign bus.blez  = (op == 6'b000110);
  assign bus.bgtz  = (op == 6'b000111);
  assign bus.addi  = (op == 6'b001000);
  assign bus.addiu = (op == 6'b001001);
  assign bus.slti  = (op == 6'b001010);
  assign bus.sltiu = (op == 6'b001011);
  assign bus.andi  = (op == 6'b001100);
  assign bus.ori   = (op == 6'b001101);
  assign bus.xori  = (op == 6'b001110);
  assign bus.lui   = (op == 6'b001111);

  assign bus.bltz = rim & (rt == 5'b00000);
  assign bus.bgez = rim & (rt == 5'b00001);

  // eret is a full-word match; rs=10000 keeps it apart from mfc0/mtc0.
  assign bus.eret = (bus.I == 32'h4200_0018);
  assign bus.mfc0 = cp0 & (rs == 5'b00000);
  assign bus.mtc0 = cp0 & (rs == 5'b00100);
endmodule

// File: tb/tb_ctrl_decoder.sv
// Randomized bench for ctrl_decoder against a mnemonic-table model.
// Literal vectors pin the model; a negedge process checks every cycle.
module tb_ctrl_decoder;
  logic clk;
  logic reset;
  ctrl_decoder_if bus ();

  ctrl_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int N = 54;
  string names [N] = '{
    "lb","lbu","lh","lhu","lw","sb","sh","sw","R",
    "add","addu","sub","subu","slt","sltu",
    "and_","or_","xor_","nor_",
    "sll","srl","sra","sllv","srlv","srav",
    "mult","multu","div","divu",
    "mfhi","mflo","mthi","mtlo",
    "addi","addiu","andi","ori","xori","lui","slti","sltiu",
    "beq","bne","blez","bgtz","bltz","bgez",
    "j","jal","jalr","jr","eret","mfc0","mtc0"};

  logic [N-1:0] dv;
  assign dv = {bus.mtc0, bus.mfc0, bus.eret, bus.jr,
    bus.jalr, bus.jal, bus.j, bus.bgez, bus.bltz,
    bus.bgtz, bus.blez, bus.bne, bus.beq,
    bus.sltiu, bus.slti, bus.lui, bus.xori, bus.ori,
    bus.andi, bus.addiu, bus.addi,
    bus.mtlo, bus.mthi, bus.mflo, bus.mfhi,
    bus.divu, bus.div, bus.multu, bus.mult,
    bus.srav, bus.srlv, bus.sllv, bus.sra, bus.srl,
    bus.sll, bus.nor_, bus.xor_, bus.or_, bus.and_,
    bus.sltu, bus.slt, bus.subu, bus.sub, bus.addu,
    bus.add, bus.R, bus.sw, bus.sh, bus.sb, bus.lw,
    bus.lhu, bus.lh, bus.lbu, bus.lb};

  int vectors = 0;
  int errs = 0;
  bit active = 0;

  // The mnemonic the instruction set assigns to a word, or "".
  function automatic string mnem(input logic [31:0] w);
    logic [5:0] op;
    logic [5:0] fn;
    op = w[31:26];
    fn = w[5:0];
    if (w == 32'h4200_0018) return "eret";
    case (op)
      6'o00: case (fn)
        6'o00: return "sll";   6'o02: return "srl";
        6'o03: return "sra";   6'o04: return "sllv";
        6'o06: return "srlv";  6'o07: return "srav";
        6'o10: return "jr";    6'o11: return "jalr";
        6'o20: return "mfhi";  6'o21: return "mthi";
        6'o22: return "mflo";  6'o23: return "mtlo";
        6'o30: return "mult";  6'o31: return "multu";
        6'o32: return "div";   6'o33: return "divu";
        6'o40: return "add";   6'o41: return "addu";
        6'o42: return "sub";   6'o43: return "subu";
        6'o44: return "and_";  6'o45: return "or_";
        6'o46: return "xor_";  6'o47: return "nor_";
        6'o52: return "slt";   6'o53: return "sltu";
        default: return "";
      endcase
      6'o01: begin
        if (w[20:16] == 0) return "bltz";
        if (w[20:16] == 1) return "bgez";
        return "";
      end
      6'o02: return "j";      6'o03: return "jal";
      6'o04: return "beq";    6'o05: return "bne";
      6'o06: return "blez";   6'o07: return "bgtz";
      6'o10: return "addi";   6'o11: return "addiu";
      6'o12: return "slti";   6'o13: return "sltiu";
      6'o14: return "andi";   6'o15: return "ori";
      6'o16: return "xori";   6'o17: return "lui";
      6'o20: begin
        if (w[25:21] == 0) return "mfc0";
        if (w[25:21] == 4) return "mtc0";
        return "";
      end
      6'o40: return "lb";     6'o41: return "lh";
      6'o43: return "lw";     6'o44: return "lbu";
      6'o45: return "lhu";    6'o50: return "sb";
      6'o51: return "sh";     6'o53: return "sw";
      default: return "";
    endcase
  endfunction

  function automatic logic [N-1:0] onehot(input string s);
    logic [N-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++)
      if (names[k] == s) v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic [N-1:0] model(input logic [31:0] w);
    logic [N-1:0] v;
    v = onehot(mnem(w));
    if (w[31:26] == 6'd0) v = v | onehot("R");
    return v;
  endfunction

  task automatic chk(input string tag, input logic [N-1:0] exp);
    vectors++;
    if (dv !== exp) begin
      errs++;
      $display("FAIL %s I=%h got=%h exp=%h",
               tag, bus.I, dv, exp);
    end
  endtask

  always @(negedge clk)
    if (active) chk("model", model(bus.I));

  task automatic apply(input logic [31:0] w);
    @(posedge clk);
    #1 bus.I = w;
  endtask

  task automatic pin(input logic [31:0] w,
                     input string a, input string b);
    @(posedge clk);
    #1 bus.I = w;
    #2 chk({"pin_", a}, onehot(a) | onehot(b));
  endtask

  logic [5:0] ops [22] = '{6'o02, 6'o03, 6'o04, 6'o05,
    6'o06, 6'o07, 6'o10, 6'o11, 6'o12, 6'o13, 6'o14,
    6'o15, 6'o16, 6'o17, 6'o40, 6'o41, 6'o43, 6'o44,
    6'o45, 6'o50, 6'o51, 6'o53};

  initial begin
    logic [31:0] w;
    reset = 1'b1;
    bus.I = 32'h0;
    repeat (2) @(posedge clk);
    #3 chk("reset_nop", onehot("R") | onehot("sll"));
    reset = 1'b0;

    pin(32'h0000_0000, "R", "sll");
    pin(32'h3C01_ABCD, "lui", "");
    pin(32'h8C22_0004, "lw", "");
    pin(32'hAC22_0004, "sw", "");
    pin(32'h0401_0003, "bgez", "");
    pin(32'h0400_0003, "bltz", "");
    pin(32'h0411_0003, "", "");
    pin(32'h4200_0018, "eret", "");
    pin(32'h4080_6000, "mtc0", "");
    pin(32'h4002_6000, "mfc0", "");
    pin(32'h0000_000C, "R", "");
    pin(32'h0043_0018, "R", "mult");
    pin(32'h03E0_0008, "R", "jr");
    pin(32'h0000_0027, "R", "nor_");
    pin(32'hFC00_0000, "", "");

    active = 1'b1;
    for (int o = 0; o < 64; o++) begin
      w = $urandom;
      w[31:26] = o[5:0];
      w[5:0] = 6'd0;
      if (o == 1) w[20:16] = 5'($urandom_range(0, 1));
      if (o == 16) w[25:21] = ($urandom_range(0, 1) != 0)
                              ? 5'd0 : 5'd4;
      apply(w);
      reset = $urandom_range(0, 1) != 0;
    end
    reset = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      w = $urandom;
      case ($urandom_range(0, 4))
        0: ;
        1: w[31:26] = 6'd0;
        2: begin
          w[31:26] = 6'd1;
          w[20:16] = 5'($urandom_range(0, 3));
        end
        3: begin
          w[31:26] = 6'd16;
          case ($urandom_range(0, 4))
            0: w[25:21] = 5'd0;
            1: w[25:21] = 5'd4;
            2: w[25:21] = 5'd16;
            3: w = 32'h4200_0018;
            default: ;
          endcase
        end
        default: w[31:26] = ops[$urandom_range(0, 21)];
      endcase
      apply(w);
      if (n % 97 == 0) reset = ~reset;
    end
    @(posedge clk);
    #1 active = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end
endmodule

// File: doc/ctrl_decoder.md
CTRL_DECODER -- requirements
Module: ctrl_decoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: clock; drives no state in this block.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset; drives no state in this block.
REQ-003 SHALL have port I, input, 32 bits: instruction word, with fields opcode=I[31:26], rs=I[25:21], rt=I[20:16], funct=I[5:0].
REQ-004 SHALL have outputs lb lbu lh lhu lw, each 1 bit: load strobes.
REQ-005 SHALL have outputs sb sh sw, each 1 bit: store strobes.
REQ-006 SHALL have output R, 1 bit: the word is in the SPECIAL (R-type) group.
REQ-007 SHALL have outputs add addu sub subu slt sltu and_ or_ xor_ nor_, each 1 bit: R-type ALU strobes.
REQ-008 SHALL have outputs sll srl sra sllv srlv srav, each 1 bit: shift strobes.
REQ-009 SHALL have outputs mult multu div divu mfhi mflo mthi mtlo, each 1 bit: HI/LO unit strobes.
REQ-010 SHALL have outputs addi addiu andi ori xori lui slti sltiu, each 1 bit: immediate ALU strobes.
REQ-011 SHALL have outputs beq bne blez bgtz bltz bgez j jal jalr jr, each 1 bit: control-flow strobes.
REQ-012 SHALL have outputs eret mfc0 mtc0, each 1 bit: CP0 strobes.

Function
REQ-013 Every output SHALL be a purely combinational function of I, settling within the same cycle, with zero-cycle latency.
REQ-014 The block SHALL contain no registers; clk and reset SHALL have no effect on the outputs.
REQ-015 Load and store decode by opcode SHALL be: lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101, sb 101000, sh 101001, sw 101011.
REQ-016 R SHALL be 1 exactly when opcode=000000, regardless of funct.
REQ-017 With opcode=000000, funct decode SHALL be:
- sll 000000, srl 000010, sra 000011
- sllv 000100, srlv 000110, srav 000111
- jr 001000, jalr 001001
- mfhi 010000, mthi 010001, mflo 010010, mtlo 010011
- mult 011000, multu 011001, div 011010, divu 011011
- add 100000, addu 100001, sub 100010, subu 100011
- and_ 100100, or_ 100101, xor_ 100110, nor_ 100111
- slt 101010, sltu 101011
REQ-018 Immediate and jump decode by opcode SHALL be: j 000010, jal 000011, beq 000100, bne 000101, blez 000110, bgtz 000111, addi 001000, addiu 001001, slti 001010, sltiu 001011, andi 001100, ori 001101, xori 001110, lui 001111.
REQ-019 With opcode=000001: bltz SHALL assert when rt=00000, and bgez SHALL assert when rt=00001; any other rt SHALL assert nothing.
REQ-020 With opcode=010000: mfc0 SHALL assert when rs=00000, mtc0 when rs=00100, and eret only when I=32'h42000018 exactly.
REQ-021 Only the fields named in REQ-015 to REQ-020 SHALL be examined; shamt, rd and other bits SHALL be ignored, except for the full-word eret match.
REQ-022 At most one instruction strobe SHALL be 1 for any I; R MAY be 1 together with one R-type strobe.
REQ-023 I=32'h00000000 (nop) SHALL decode as R=1, sll=1.
REQ-024 An undefined opcode, or an undefined funct under opcode 000000, SHALL drive every instruction strobe to 0; R SHALL still follow REQ-016.
REQ-025 The block SHALL contain no latches, and X on I SHALL not be masked.

Reset
REQ-026 Asserting reset SHALL leave the outputs unchanged, since they depend only on I.
REQ-027 An upstream pipeline register that clears I to 0 on reset SHALL therefore yield the nop decode (R=1, sll=1, all else 0).

Verification
REQ-028 I=32'h00000000 -> R=1, sll=1, all other outputs 0.
REQ-029 I=32'h3C01ABCD -> lui=1 only; I=32'h8C220004 -> lw=1 only; I=32'hAC220004 -> sw=1 only.
REQ-030 I=32'h04010003 -> bgez=1 only; I=32'h04000003 -> bltz=1 only; I=32'h04110003 -> all outputs 0.
REQ-031 I=32'h42000018 -> eret=1 only; I=32'h40806000 -> mtc0=1 only; I=32'h40026000 -> mfc0=1 only.
REQ-032 I=32'h0000000C (undefined funct) -> R=1, all other outputs 0; I=32'h00430018 -> R=1, mult=1; I=32'h03E00008 -> R=1, jr=1.
REQ-033 Sweep all 64 opcodes with funct=0 and check the single expected strobe per REQ-015 to REQ-020; toggling clk or reset during the sweep SHALL not change any output.
